// File: rtl/commit_trace_buf_if.sv
// Commit-trace bundle: core commit fields, arm/clear control, and the drain port with status.
// The master side feeds commits and consumes records; the slave side is the trace buffer.
interface commit_trace_buf_if #(
    parameter int XLEN = 32,
    parameter int CW   = 5
);
    logic            arm;
    logic            clear;
    logic            in_commit;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            in_halt;
    logic            in_reg_we;
    logic [4:0]      in_reg_wa;
    logic [XLEN-1:0] in_reg_wd;
    logic            in_dmem_we;
    logic [XLEN-1:0] in_dmem_wa;
    logic [XLEN-1:0] in_dmem_wd;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_halt;
    logic            out_reg_we;
    logic [4:0]      out_reg_wa;
    logic [XLEN-1:0] out_reg_wd;
    logic            out_dmem_we;
    logic [XLEN-1:0] out_dmem_wa;
    logic [XLEN-1:0] out_dmem_wd;

    logic [CW-1:0]   count;
    logic [15:0]     drop_cnt;
    logic [1:0]      state;

    modport master (
        output arm, clear, in_commit, in_pc, in_inst, in_halt, in_reg_we, in_reg_wa,
               in_reg_wd, in_dmem_we, in_dmem_wa, in_dmem_wd, out_ready,
        input  out_valid, out_pc, out_inst, out_halt, out_reg_we, out_reg_wa, out_reg_wd,
               out_dmem_we, out_dmem_wa, out_dmem_wd, count, drop_cnt, state
    );

    modport slave (
        input  arm, clear, in_commit, in_pc, in_inst, in_halt, in_reg_we, in_reg_wa,
               in_reg_wd, in_dmem_we, in_dmem_wa, in_dmem_wd, out_ready,
        output out_valid, out_pc, out_inst, out_halt, out_reg_we, out_reg_wa, out_reg_wd,
               out_dmem_we, out_dmem_wa, out_dmem_wd, count, drop_cnt, state
    );
endinterface

// File: rtl/commit_trace_buf.sv
// Commit-trace capture FIFO with arm/freeze control, halt-triggered stop and
// drop-or-overwrite full policy; records drain first-word-fall-through.
module commit_trace_buf #(
    parameter int DEPTH       = 16,
    parameter int XLEN        = 32,
    parameter int WRAP_MODE   = 0,
    parameter int HALT_FREEZE = 1
) (
    input  logic                clk,
    input  logic                rst,
    commit_trace_buf_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 5 * XLEN + 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   rptr_q;
    logic [AW-1:0]   rptr_d;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   wptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [15:0]     drop_q;
    logic [15:0]     drop_d;

    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            wr_en_s;
    logic            drop_s;
    logic            overwrite_s;
    logic            cnt_inc_s;
    logic [RW-1:0]   wr_rec_s;
    logic [RW-1:0]   rd_rec_s;

    assign wr_rec_s = {bus.in_pc, bus.in_inst, bus.in_halt, bus.in_reg_we, bus.in_reg_wa,
                       bus.in_reg_wd, bus.in_dmem_we, bus.in_dmem_wa, bus.in_dmem_wd};

    // Push/pop qualification and pointer/count/drop next-state
    always_comb begin
        push_s      = (state_q == ST_CAPTURE) && bus.in_commit;
        pop_s       = (count_q != {CW{1'b0}}) && bus.out_ready;
        full_s      = (count_q == CW'(DEPTH));
        // A full buffer only loses a record when no pop frees a slot this cycle
        drop_s      = push_s && full_s && !pop_s;
        overwrite_s = drop_s && (WRAP_MODE != 0);
        wr_en_s     = push_s && (!drop_s || overwrite_s);
        cnt_inc_s   = wr_en_s && !overwrite_s;

        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        drop_d      = drop_q;
        if (pop_s || overwrite_s) begin
            rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        if (wr_en_s) begin
            wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        count_d = count_q + {{(CW-1){1'b0}}, cnt_inc_s} - {{(CW-1){1'b0}}, pop_s};
        if (drop_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Capture-control FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (push_s && bus.in_halt && (HALT_FREEZE != 0)) begin
                    state_d = ST_FROZEN;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_FROZEN: begin
                if (bus.arm) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_FROZEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, occupancy and drop-counter registers
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            rptr_q  <= {AW{1'b0}};
            wptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            drop_q  <= 16'd0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Record storage; contents are don't-care until the pointers make them visible
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst && !bus.clear) begin
            mem_q[wptr_q] <= wr_rec_s;
        end
    end

    assign rd_rec_s = mem_q[rptr_q];

    assign {bus.out_pc, bus.out_inst, bus.out_halt, bus.out_reg_we, bus.out_reg_wa,
            bus.out_reg_wd, bus.out_dmem_we, bus.out_dmem_wa, bus.out_dmem_wd} = rd_rec_s;

    assign bus.out_valid = (count_q != {CW{1'b0}});
    assign bus.count     = count_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Random + directed bench for commit_trace_buf: two DEPTH=4 instances (drop/freeze and
// wrap/no-freeze) share stimulus and are compared against a queue-based reference model.
module tb_commit_trace_buf;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
    } rec_t;

    logic clk = 1'b0;
    logic rst_v;
    logic arm_v, clear_v, commit_v, ready_v;
    rec_t rec_v;

    int total = 0;
    int bad   = 0;

    rec_t mq [2][$];
    int   mst [2];
    int   mdrop [2];

    always #5 clk = ~clk;

    commit_trace_buf_if #(.XLEN(XLEN), .CW(CW)) bus0 ();
    commit_trace_buf_if #(.XLEN(XLEN), .CW(CW)) bus1 ();

    assign bus0.arm = arm_v;          assign bus1.arm = arm_v;
    assign bus0.clear = clear_v;      assign bus1.clear = clear_v;
    assign bus0.in_commit = commit_v; assign bus1.in_commit = commit_v;
    assign bus0.out_ready = ready_v;  assign bus1.out_ready = ready_v;
    assign bus0.in_pc = rec_v.pc;     assign bus1.in_pc = rec_v.pc;
    assign bus0.in_inst = rec_v.inst; assign bus1.in_inst = rec_v.inst;
    assign bus0.in_halt = rec_v.halt; assign bus1.in_halt = rec_v.halt;
    assign bus0.in_reg_we = rec_v.reg_we;   assign bus1.in_reg_we = rec_v.reg_we;
    assign bus0.in_reg_wa = rec_v.reg_wa;   assign bus1.in_reg_wa = rec_v.reg_wa;
    assign bus0.in_reg_wd = rec_v.reg_wd;   assign bus1.in_reg_wd = rec_v.reg_wd;
    assign bus0.in_dmem_we = rec_v.dmem_we; assign bus1.in_dmem_we = rec_v.dmem_we;
    assign bus0.in_dmem_wa = rec_v.dmem_wa; assign bus1.in_dmem_wa = rec_v.dmem_wa;
    assign bus0.in_dmem_wd = rec_v.dmem_wd; assign bus1.in_dmem_wd = rec_v.dmem_wd;

    commit_trace_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .WRAP_MODE(0), .HALT_FREEZE(1)) dut0 (
        .clk(clk), .rst(rst_v), .bus(bus0));
    commit_trace_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .WRAP_MODE(1), .HALT_FREEZE(0)) dut1 (
        .clk(clk), .rst(rst_v), .bus(bus1));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of records, updated by the rules for one clock edge
    task automatic model_step(input int k, input bit wrap, input bit hf);
        bit pop, push;
        if (clear_v || rst_v) begin
            mq[k].delete();
            mdrop[k] = 0;
            mst[k]   = 0;
            return;
        end
        pop  = ready_v && (mq[k].size() != 0);
        push = (mst[k] == 1) && commit_v;
        if (pop) void'(mq[k].pop_front());
        if (push) begin
            if (mq[k].size() < DEPTH) begin
                mq[k].push_back(rec_v);
            end else begin
                if (wrap) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back(rec_v);
                end
                if (mdrop[k] < 65535) mdrop[k] = mdrop[k] + 1;
            end
        end
        case (mst[k])
            0: if (arm_v) mst[k] = 1;
            1: if (push && rec_v.halt && hf) mst[k] = 2;
            2: if (arm_v) mst[k] = 1;
            default: mst[k] = 0;
        endcase
    endtask

    task automatic cmp_dut(input int k, input logic [1:0] st, input logic [CW-1:0] cnt,
                           input logic [15:0] drp, input logic vld, input rec_t o);
        chk($sformatf("state%0d", k), 256'(st), 256'(mst[k]));
        chk($sformatf("count%0d", k), 256'(cnt), 256'(mq[k].size()));
        chk($sformatf("drop%0d", k), 256'(drp), 256'(mdrop[k]));
        chk($sformatf("valid%0d", k), 256'(vld), 256'(mq[k].size() != 0));
        if (mq[k].size() != 0) chk($sformatf("rec%0d", k), 256'(o), 256'(mq[k][0]));
    endtask

    task automatic compare_all();
        rec_t o0, o1;
        o0 = {bus0.out_pc, bus0.out_inst, bus0.out_halt, bus0.out_reg_we, bus0.out_reg_wa,
              bus0.out_reg_wd, bus0.out_dmem_we, bus0.out_dmem_wa, bus0.out_dmem_wd};
        o1 = {bus1.out_pc, bus1.out_inst, bus1.out_halt, bus1.out_reg_we, bus1.out_reg_wa,
              bus1.out_reg_wd, bus1.out_dmem_we, bus1.out_dmem_wa, bus1.out_dmem_wd};
        cmp_dut(0, bus0.state, bus0.count, bus0.drop_cnt, bus0.out_valid, o0);
        cmp_dut(1, bus1.state, bus1.count, bus1.drop_cnt, bus1.out_valid, o1);
    endtask

    // Inputs are set at the falling edge; the model and DUT both see them at the next rise
    task automatic cycle();
        model_step(0, 1'b0, 1'b1);
        model_step(1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        rst_v = 1'b0; arm_v = 1'b0; clear_v = 1'b0; commit_v = 1'b0; ready_v = 1'b0;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] inst, input logic halt);
        commit_v      = 1'b1;
        rec_v.pc      = pc;
        rec_v.inst    = inst;
        rec_v.halt    = halt;
        rec_v.reg_we  = 1'($urandom);
        rec_v.reg_wa  = 5'($urandom);
        rec_v.reg_wd  = $urandom;
        rec_v.dmem_we = 1'($urandom);
        rec_v.dmem_wa = $urandom;
        rec_v.dmem_wd = $urandom;
    endtask

    task automatic arm_cycle();
        idle_inputs(); arm_v = 1'b1; cycle(); idle_inputs();
    endtask

    task automatic clear_cycle();
        idle_inputs(); clear_v = 1'b1; cycle(); idle_inputs();
    endtask

    initial begin
        logic [31:0] exp_drop [4];
        logic [31:0] exp_wrap [4];
        exp_drop = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_wrap = '{32'h8, 32'hC, 32'h10, 32'h14};
        rec_v = '0;
        idle_inputs();
        @(negedge clk);
        rst_v = 1'b1;
        cycle();
        idle_inputs();
        chk("rst_state", 256'(bus0.state), 256'(0));
        chk("rst_count", 256'(bus0.count), 256'(0));
        chk("rst_valid", 256'(bus0.out_valid), 256'(0));

        // Three commits held, then drained in order
        arm_cycle();
        for (int i = 0; i < 3; i++) begin set_commit(32'(4 * i), $urandom, 1'b0); cycle(); end
        idle_inputs();
        chk("t1_count", 256'(bus0.count), 256'(3));
        ready_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_pc", 256'(bus0.out_pc), 256'(4 * i));
            cycle();
        end
        chk("t1_empty", 256'(bus0.out_valid), 256'(0));

        // Six commits into DEPTH=4: drop vs overwrite
        clear_cycle();
        arm_cycle();
        for (int i = 0; i < 6; i++) begin set_commit(32'(4 * i), $urandom, 1'b0); cycle(); end
        idle_inputs();
        chk("t2_cnt0", 256'(bus0.count), 256'(4));
        chk("t2_drop0", 256'(bus0.drop_cnt), 256'(2));
        chk("t2_cnt1", 256'(bus1.count), 256'(4));
        chk("t2_drop1", 256'(bus1.drop_cnt), 256'(2));
        ready_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_pc0", 256'(bus0.out_pc), 256'(exp_drop[i]));
            chk("t2_pc1", 256'(bus1.out_pc), 256'(exp_wrap[i]));
            cycle();
        end

        // Halt freezes the freeze-enabled instance only
        clear_cycle();
        arm_cycle();
        set_commit(32'h100, 32'h00100073, 1'b1); cycle();
        for (int i = 0; i < 2; i++) begin set_commit(32'h104 + 32'(4 * i), $urandom, 1'b0); cycle(); end
        idle_inputs();
        chk("t3_state0", 256'(bus0.state), 256'(2));
        chk("t3_count0", 256'(bus0.count), 256'(1));
        chk("t3_inst0", 256'(bus0.out_inst), 256'(32'h00100073));
        chk("t3_state1", 256'(bus1.state), 256'(1));
        arm_cycle();
        chk("t3_rearm", 256'(bus0.state), 256'(1));
        set_commit(32'h200, $urandom, 1'b0); cycle(); idle_inputs();
        chk("t3_count0b", 256'(bus0.count), 256'(2));

        // Full buffer with simultaneous push and pop
        clear_cycle();
        arm_cycle();
        for (int i = 0; i < 4; i++) begin set_commit(32'(4 * i), $urandom, 1'b0); cycle(); end
        for (int i = 0; i < 10; i++) begin
            set_commit(32'h40 + 32'(4 * i), $urandom, 1'b0); ready_v = 1'b1; cycle();
        end
        idle_inputs();
        chk("t4_count", 256'(bus0.count), 256'(4));
        chk("t4_drop", 256'(bus0.drop_cnt), 256'(0));
        chk("t4_head", 256'(bus0.out_pc), 256'(32'h58));

        // Clear beats arm, commit and pop in the same cycle
        set_commit(32'h99, $urandom, 1'b0); cycle();
        chk("t5_predrop", 256'(bus0.drop_cnt), 256'(1));
        set_commit(32'h9C, $urandom, 1'b0); arm_v = 1'b1; clear_v = 1'b1; ready_v = 1'b1;
        cycle(); idle_inputs();
        chk("t5_state", 256'(bus0.state), 256'(0));
        chk("t5_count", 256'(bus0.count), 256'(0));
        chk("t5_drop", 256'(bus0.drop_cnt), 256'(0));
        chk("t5_valid", 256'(bus1.out_valid), 256'(0));

        // Reset mid-operation
        arm_cycle();
        set_commit(32'h300, $urandom, 1'b0); cycle();
        idle_inputs(); rst_v = 1'b1; cycle(); idle_inputs();
        chk("t6_count", 256'(bus0.count), 256'(0));
        chk("t6_state", 256'(bus0.state), 256'(0));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst_v   = ($urandom_range(0, 199) == 0);
            clear_v = ($urandom_range(0, 59) == 0);
            arm_v   = ($urandom_range(0, 9) == 0);
            ready_v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 6) set_commit($urandom, $urandom, ($urandom_range(0, 19) == 0));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
